sa_ctrl: RTL

Top-level sequencer for one systolic-array pass.
- On `start`, triggers the weight address generator (ag_w) to load W_i into the array DPRs and waits for it to finish.
- Then streams `num_vec` input vectors through the array under input-buffer flow control.
- Then drains the array pipeline and signals completion.
- Sits between the host/command logic and ag_w, the input buffer and the array enable.

---
 rtl/sa_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/sa_ctrl.sv
// Pass sequencer for the systolic array: weight load via ag_w, vector feed
// under input-buffer flow control, pipeline drain, then a completion pulse.
module sa_ctrl #(
  parameter int FEATURE_BITS = 4,
  parameter int VEC_BITS     = 8,
  parameter int DRAIN_CYCLES = 15
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                start,
  input  logic [VEC_BITS-1:0] num_vec,
  output logic                ag_start,
  input  logic                ag_done,
  input  logic                in_ready,
  output logic                feed_en,
  output logic [VEC_BITS-1:0] vec_idx,
  output logic                acc_clr,
  output logic                sa_en,
  output logic                busy,
  output logic                done
);

  localparam int DIM       = 2 ** (FEATURE_BITS - 1);
  // Counter is wide enough for the nominal 2*dim flush even if DRAIN_CYCLES is tuned lower.
  localparam int DRAIN_MAX = (DRAIN_CYCLES > 2 * DIM) ? DRAIN_CYCLES : 2 * DIM;
  localparam int DRAIN_W   = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    WAIT_W = 3'd2,
    FEED   = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t              state_reg, state_next;
  logic [VEC_BITS-1:0] vec_cnt_reg, vec_cnt_next;
  logic [VEC_BITS-1:0] num_vec_reg, num_vec_next;
  logic [DRAIN_W-1:0]  drain_cnt_reg, drain_cnt_next;
  logic                ag_start_reg, acc_clr_reg, busy_reg, done_reg;
  logic                last_vec;

  // The index stops at num_vec-1, so a full-scale count never wraps.
  assign last_vec = (vec_cnt_reg == num_vec_reg - VEC_BITS'(1));

  always_comb begin
    state_next     = state_reg;
    vec_cnt_next   = vec_cnt_reg;
    num_vec_next   = num_vec_reg;
    drain_cnt_next = drain_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          vec_cnt_next = '0;
          if (num_vec != '0) begin
            num_vec_next = num_vec;
            state_next   = LOAD_W;
          end else begin
            state_next   = DONE;
          end
        end
      end
      LOAD_W: state_next = WAIT_W;
      WAIT_W: begin
        if (ag_done) state_next = FEED;
      end
      FEED: begin
        if (in_ready) begin
          if (last_vec) begin
            state_next     = DRAIN;
            drain_cnt_next = DRAIN_W'(DRAIN_CYCLES - 1);
          end else begin
            vec_cnt_next   = vec_cnt_reg + VEC_BITS'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_cnt_reg == '0) state_next = DONE;
        else drain_cnt_next = drain_cnt_reg - DRAIN_W'(1);
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs that depend only on state are registered from the next-state decode.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      vec_cnt_reg   <= '0;
      num_vec_reg   <= '0;
      drain_cnt_reg <= '0;
      ag_start_reg  <= 1'b0;
      acc_clr_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      vec_cnt_reg   <= vec_cnt_next;
      num_vec_reg   <= num_vec_next;
      drain_cnt_reg <= drain_cnt_next;
      ag_start_reg  <= (state_next == LOAD_W);
      acc_clr_reg   <= (state_next == FEED) && (state_reg != FEED);
      busy_reg      <= (state_next != IDLE);
      done_reg      <= (state_next == DONE);
    end
  end

  assign ag_start = ag_start_reg;
  assign acc_clr  = acc_clr_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign vec_idx  = vec_cnt_reg;
  assign feed_en  = (state_reg == FEED) && in_ready;
  assign sa_en    = feed_en || (state_reg == DRAIN);

endmodule
